uart_cmd_parser: RTL
====================

# uart_cmd_parser

ASCII command parser sitting directly downstream of `uart_rx` and upstream of `uart_tx` in the Artix7 UART designs. It consumes received bytes (`data_rdy`/`data_rx`), decodes single-line hex read/write commands into one-cycle register-bus strobes, and streams an ASCII response back through the transmitter. It replaces the fixed loopback path with a host-controllable 8-bit register interface.

## Interface
- `RD_LATENCY`, default 1: cycles from `rd_en` to valid `rd_data`, 1..4.
- `clk`  in  1  system clock, the 100 MHz tree clock.
- `reset`  in  1  asynchronous, active-high reset.
- `rx_rdy`  in  1  one-cycle pulse, `rx_data` valid; from `uart_rx.data_rdy`.
- `rx_data`  in  8  received byte.
- `tx_busy`  in  1  transmitter busy; high from the cycle after `tx_en` until the stop bit completes.
- `tx_en`  out  1  one-cycle pulse, send `tx_data`.
- `tx_data`  out  8  response byte, held until the next `tx_en`.
- `wr_en`  out  1  one-cycle write strobe.
- `rd_en`  out  1  one-cycle read strobe.
- `addr`  out  8  register address, valid with `wr_en`/`rd_en`, held afterwards.
- `wr_data`  out  8  write data, valid with `wr_en`.
- `rd_data`  in  8  read data, sampled `RD_LATENCY` cycles after `rd_en`.
- `err_ovf`  out  1  one-cycle pulse when an rx byte is dropped.

## Operation
- Command grammar: `W` aa dd CR writes; `R` aa CR reads.
  - Letters are case-insensitive.
  - Hex digits accept 0-9, A-F, a-f.
  - CR is 0x0D.
- LF (0x0A) is silently ignored in IDLE only.
- States: IDLE, A_HI, A_LO, D_HI, D_LO, WAIT_CR, EXEC, RD_WAIT, SEND, DISCARD.
- IDLE: on `W`/`R`, latch the opcode and go to A_HI. Any other non-LF byte queues `?` and goes to DISCARD.
- A_HI → A_LO → (write: D_HI → D_LO) → WAIT_CR. Each step consumes one valid hex byte; nibbles assemble MSB first.
- Any invalid byte in A_HI..WAIT_CR, including an extra hex digit before CR, queues `?` and goes to DISCARD.
- A CR arriving early in A_HI..D_LO: `?`, then IDLE. It is not DISCARD, because the CR already ended the line.
- DISCARD: drop bytes until CR, then IDLE. The pending `?` is still sent, and DISCARD ends only after both the `?` and the CR.
- WAIT_CR + CR → EXEC.
  - Write: `wr_en` pulses, then response `K` (0x4B), then SEND.
  - Read: `rd_en` pulses, then RD_WAIT.
- RD_WAIT: capture `rd_data` after `RD_LATENCY` cycles. Response is the uppercase hex high char, low char, then CR (3 bytes); then SEND.
- SEND: the response buffer is up to 3 bytes with a count.
  - Emit the next byte via `tx_en` when `tx_busy`=0 and the post-send guard cycle has elapsed.
  - After the last byte, go to IDLE.
- Overrun: `rx_rdy` in EXEC, RD_WAIT or SEND drops the byte and pulses `err_ovf` in the following cycle. The state and the response are unaffected.
- Reset (any time, including mid-SEND):
  - all outputs 0, `tx_data`=0, `addr`=0, `wr_data`=0;
  - state IDLE, response buffer empty.
  - No partial strobes after reset release.

## Timing
- All outputs are registered.
- `wr_en`/`rd_en`: asserted in the cycle after the cycle where `rx_rdy` carried the CR.
- `addr`/`wr_data` are valid in that same cycle.
- First `tx_en`:
  - Write: no earlier than 1 cycle after `wr_en`.
  - Read: `RD_LATENCY`+1 cycles after `rd_en`, gated by `tx_busy`.
- Guard: after each `tx_en`, at least 1 idle cycle before `tx_busy` is sampled again, which covers `tx_busy` rising one cycle late.
- `rx_rdy` pulses are at least 2 cycles apart. The parser accepts back-to-back pulses spaced 2 cycles apart in parse states.
- `rx_rdy` coincident with the final `tx_en` of SEND counts as overrun; the transition to IDLE happens the next cycle.

## Structure
- `uart_cmd_defs.vh` (shared include):
  - ASCII localparams: CR, LF, `W`, `R`, `K`, `?`.
  - State encodings.
  - Hex-to-nibble and nibble-to-hex functions, reused by future monitor blocks.
- One sub-module, `uart_cmd_resp`: the 3-byte response buffer, count, guard cycle and `tx_busy` handshake. Its interface is load strobe, 3 bytes, length, and a done pulse.
- Top-level parser FSM plus the read-latency shift counter: about 250 lines total.

## Test plan
- "W1A5F\r" → one `wr_en` with `addr`=0x1A, `wr_data`=0x5F; `tx_en` once with 0x4B.
- "r3c\r", `rd_data`=0xB7, RD_LATENCY=1 → `rd_en` with `addr`=0x3C; tx 0x42, 0x37, 0x0D in order, each only while `tx_busy`=0.
- "WZ1\r" → tx 0x3F after `Z`; no `wr_en`; back in IDLE after CR; a following "W0001\r" works.
- "W12345\r" → `?` on `5`, no `wr_en`. "R1\r" → `?`, IDLE, no `rd_en`.
- During a read response with `tx_busy` held high 20 cycles, inject byte 0x41 → `err_ovf` pulses once; response bytes are unchanged.
- Assert `reset` mid-SEND after the first byte → all outputs 0 within the same cycle; no further `tx_en`; "\n" then "R00\r" after release behaves normally.

Source files
------------

// File: rtl/uart_cmd_parser_pkg.sv
// Shared definitions for the UART command parser.
// Holds the ASCII codes of the command grammar, the parser state encoding and
// the hex/nibble conversion helpers reused by monitor blocks.
package uart_cmd_parser_pkg;

  localparam logic [7:0] AsciiCr = 8'h0D;
  localparam logic [7:0] AsciiLf = 8'h0A;
  localparam logic [7:0] AsciiW  = 8'h57;
  localparam logic [7:0] AsciiR  = 8'h52;
  localparam logic [7:0] AsciiK  = 8'h4B;
  localparam logic [7:0] AsciiQ  = 8'h3F;

  typedef enum logic [3:0] {
    StIdle,
    StAHi,
    StALo,
    StDHi,
    StDLo,
    StWaitCr,
    StExec,
    StRdWait,
    StSend,
    StDiscard
  } state_e;

  // Returns {valid, nibble}; accepts 0-9, A-F, a-f.
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    logic [7:0] u;
    u = c & 8'hDF;
    if (c >= 8'h30 && c <= 8'h39) return {1'b1, c[3:0]};
    if (u >= 8'h41 && u <= 8'h46) return {1'b1, c[3:0] + 4'd9};
    return 5'h00;
  endfunction

  // Uppercase ASCII hex character for a nibble.
  function automatic logic [7:0] nib_to_hex(input logic [3:0] n);
    if (n < 4'd10) return {4'h3, n};
    return 8'h37 + {4'h0, n};
  endfunction

  // Case-insensitive compare against an uppercase letter.
  function automatic logic is_letter(input logic [7:0] c, input logic [7:0] letter);
    return (c & 8'hDF) == letter;
  endfunction

endpackage

// File: rtl/uart_cmd_parser_resp.sv
// Response buffer for the UART command parser.
// Holds up to three bytes, hands them to the transmitter one at a time and
// pulses done together with the final tx_en.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   load         one-cycle strobe, capture data/len (buffer must be empty)
//   data         three bytes, byte 0 in [7:0] is sent first
//   len          number of bytes to send, 1..3
//   tx_busy      transmitter busy
//   tx_en        one-cycle send strobe
//   tx_data      byte being sent, held until the next tx_en
//   done         one-cycle pulse coincident with the last tx_en
module uart_cmd_parser_resp (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [23:0] data,
  input  logic [1:0]  len,
  input  logic        tx_busy,
  output logic        tx_en,
  output logic [7:0]  tx_data,
  output logic        done
);

  logic [23:0] shift_q, shift_d, shift_n;
  logic [1:0]  cnt_q, cnt_d, cnt_n;
  logic        guard_q;
  logic        tx_en_q, tx_en_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        done_q, done_d;
  logic        ready;

  always_comb begin
    shift_n = shift_q;
    cnt_n   = cnt_q;
    if (load) begin
      shift_n = data;
      cnt_n   = len;
    end
    // tx_busy may rise one cycle late, so it is ignored during the tx_en
    // cycle and the guard cycle after it.
    ready     = (cnt_n != 2'd0) && !tx_busy && !tx_en_q && !guard_q;
    shift_d   = shift_n;
    cnt_d     = cnt_n;
    tx_en_d   = 1'b0;
    tx_data_d = tx_data_q;
    done_d    = 1'b0;
    if (ready) begin
      tx_en_d   = 1'b1;
      tx_data_d = shift_n[7:0];
      shift_d   = {8'h00, shift_n[23:8]};
      cnt_d     = cnt_n - 2'd1;
      done_d    = (cnt_n == 2'd1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q   <= '0;
      cnt_q     <= '0;
      guard_q   <= 1'b0;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      guard_q   <= tx_en_q;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
      done_q    <= done_d;
    end
  end

  assign tx_en   = tx_en_q;
  assign tx_data = tx_data_q;
  assign done    = done_q;

endmodule

// File: rtl/uart_cmd_parser.sv
// ASCII hex command parser between uart_rx and uart_tx.
// "W aa dd CR" writes, "R aa CR" reads; replies "K", "hh CR" or "?".
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   rx_rdy, rx_data received byte strobe and value
//   tx_busy         transmitter busy
//   tx_en, tx_data  response byte strobe and value
//   wr_en, rd_en    one-cycle register strobes
//   addr, wr_data   register address and write data
//   rd_data         read data, sampled RD_LATENCY cycles after rd_en
//   err_ovf         pulse when a received byte is dropped
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  input  logic       tx_busy,
  output logic       tx_en,
  output logic [7:0] tx_data,
  output logic       wr_en,
  output logic       rd_en,
  output logic [7:0] addr,
  output logic [7:0] wr_data,
  input  logic [7:0] rd_data,
  output logic       err_ovf
);

  state_e      state_q, state_d;
  logic        is_write_q, is_write_d;
  logic [7:0]  addr_sh_q, addr_sh_d;
  logic [7:0]  data_sh_q, data_sh_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        wr_en_q, wr_en_d;
  logic        rd_en_q, rd_en_d;
  logic        err_ovf_q, err_ovf_d;
  logic        cr_seen_q, cr_seen_d;
  logic        sent_q, sent_d;
  logic [2:0]  lat_cnt_q, lat_cnt_d;

  logic        resp_load;
  logic [23:0] resp_data;
  logic [1:0]  resp_len;
  logic        resp_done;

  logic [4:0]  hex;
  logic        is_cr;
  logic        bad;

  always_comb begin
    state_d    = state_q;
    is_write_d = is_write_q;
    addr_sh_d  = addr_sh_q;
    data_sh_d  = data_sh_q;
    addr_d     = addr_q;
    wr_data_d  = wr_data_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    cr_seen_d  = cr_seen_q;
    sent_d     = sent_q;
    lat_cnt_d  = lat_cnt_q;
    resp_load  = 1'b0;
    resp_data  = '0;
    resp_len   = 2'd0;
    bad        = 1'b0;
    hex        = hex_decode(rx_data);
    is_cr      = (rx_data == AsciiCr);
    err_ovf_d  = rx_rdy && (state_q inside {StExec, StRdWait, StSend});

    unique case (state_q)
      StIdle: begin
        if (rx_rdy && rx_data != AsciiLf) begin
          if (is_letter(rx_data, AsciiW) || is_letter(rx_data, AsciiR)) begin
            is_write_d = is_letter(rx_data, AsciiW);
            state_d    = StAHi;
          end else begin
            bad = 1'b1;
          end
        end
      end
      StAHi: begin
        if (rx_rdy) begin
          if (hex[4]) begin
            addr_sh_d[7:4] = hex[3:0];
            state_d        = StALo;
          end else begin
            bad = 1'b1;
          end
        end
      end
      StALo: begin
        if (rx_rdy) begin
          if (hex[4]) begin
            addr_sh_d[3:0] = hex[3:0];
            state_d        = is_write_q ? StDHi : StWaitCr;
          end else begin
            bad = 1'b1;
          end
        end
      end
      StDHi: begin
        if (rx_rdy) begin
          if (hex[4]) begin
            data_sh_d[7:4] = hex[3:0];
            state_d        = StDLo;
          end else begin
            bad = 1'b1;
          end
        end
      end
      StDLo: begin
        if (rx_rdy) begin
          if (hex[4]) begin
            data_sh_d[3:0] = hex[3:0];
            state_d        = StWaitCr;
          end else begin
            bad = 1'b1;
          end
        end
      end
      StWaitCr: begin
        if (rx_rdy) begin
          if (is_cr) begin
            state_d = StExec;
            addr_d  = addr_sh_q;
            if (is_write_q) begin
              wr_en_d   = 1'b1;
              wr_data_d = data_sh_q;
            end else begin
              rd_en_d = 1'b1;
            end
          end else begin
            bad = 1'b1;
          end
        end
      end
      StExec: begin
        if (is_write_q) begin
          resp_load = 1'b1;
          resp_data = {16'h0000, AsciiK};
          resp_len  = 2'd1;
          state_d   = StSend;
        end else begin
          lat_cnt_d = 3'd1;
          state_d   = StRdWait;
        end
      end
      StRdWait: begin
        if (lat_cnt_q == RD_LATENCY[2:0]) begin
          resp_load = 1'b1;
          resp_data = {AsciiCr, nib_to_hex(rd_data[3:0]), nib_to_hex(rd_data[7:4])};
          resp_len  = 2'd3;
          state_d   = StSend;
        end else begin
          lat_cnt_d = lat_cnt_q + 3'd1;
        end
      end
      StSend: begin
        if (resp_done) state_d = StIdle;
      end
      StDiscard: begin
        // Leave only once both the line has ended and the '?' is out.
        if (rx_rdy && is_cr) cr_seen_d = 1'b1;
        if (resp_done) sent_d = 1'b1;
        if (cr_seen_d && sent_d) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A CR that is itself the bad byte already ended the line: just reply.
    if (bad) begin
      resp_load = 1'b1;
      resp_data = {16'h0000, AsciiQ};
      resp_len  = 2'd1;
      state_d   = is_cr ? StSend : StDiscard;
      cr_seen_d = 1'b0;
      sent_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      is_write_q <= 1'b0;
      addr_sh_q  <= '0;
      data_sh_q  <= '0;
      addr_q     <= '0;
      wr_data_q  <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      err_ovf_q  <= 1'b0;
      cr_seen_q  <= 1'b0;
      sent_q     <= 1'b0;
      lat_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      is_write_q <= is_write_d;
      addr_sh_q  <= addr_sh_d;
      data_sh_q  <= data_sh_d;
      addr_q     <= addr_d;
      wr_data_q  <= wr_data_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      err_ovf_q  <= err_ovf_d;
      cr_seen_q  <= cr_seen_d;
      sent_q     <= sent_d;
      lat_cnt_q  <= lat_cnt_d;
    end
  end

  uart_cmd_parser_resp u_resp (
    .clk     (clk),
    .reset   (reset),
    .load    (resp_load),
    .data    (resp_data),
    .len     (resp_len),
    .tx_busy (tx_busy),
    .tx_en   (tx_en),
    .tx_data (tx_data),
    .done    (resp_done)
  );

  assign wr_en   = wr_en_q;
  assign rd_en   = rd_en_q;
  assign addr    = addr_q;
  assign wr_data = wr_data_q;
  assign err_ovf = err_ovf_q;

endmodule
